// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-write-port register file with PC read slot and long-latency scoreboard
// Port 4 carries long-latency writebacks and retires the claims made on claim_en.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int PC_IDX = 2**AW-1,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [DW-1:0] pc_in,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [DW-1:0] wd3,
  input  logic          we4,
  input  logic [AW-1:0] wa4,
  input  logic [DW-1:0] wd4,
  input  logic          claim_en,
  input  logic [AW-1:0] claim_addr,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   pend_cnt,
  output logic          waw_err
);

  localparam int            NREG = 2**AW;
  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DW-1:0]   mem [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [AW:0]     cnt_nxt;
  logic            waw_nxt;
  logic            fwd_ok;

  // Forwarding is suppressed in reset so reads show the cleared storage.
  assign fwd_ok = (BYPASS != 0) && reset;

  function automatic logic [DW-1:0] rd_sel(input logic [AW-1:0] ra);
    if (ra == PC_A)
      return pc_in;
    else if (fwd_ok && we4 && wa4 == ra)
      return wd4;
    else if (fwd_ok && we3 && wa3 == ra)
      return wd3;
    else
      return mem[ra];
  endfunction

  function automatic logic busy_sel(input logic [AW-1:0] ra);
    return pending[ra] && (ra != PC_A) && !(fwd_ok && we4 && wa4 == ra);
  endfunction

  assign rd1   = rd_sel(ra1);
  assign rd2   = rd_sel(ra2);
  assign busy1 = busy_sel(ra1);
  assign busy2 = busy_sel(ra2);

  // Clear before set so a claim landing with its own retire stays pending.
  always_comb begin
    pending_nxt = pending;
    if (we4)
      pending_nxt[wa4] = 1'b0;
    if (claim_en)
      pending_nxt[claim_addr] = 1'b1;
    pending_nxt[PC_A] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(pending_nxt[i]);
  end

  assign waw_nxt = we3 && (wa3 != PC_A) && pending[wa3] && !(we4 && wa4 == wa3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      pend_cnt <= '0;
      waw_err  <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
      waw_err  <= waw_nxt;
    end
  end

  // Port 4 is written last so it wins an address collision with port 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else begin
      if (we3 && wa3 != PC_A)
        mem[wa3] <= wd3;
      if (we4 && wa4 != PC_A)
        mem[wa4] <= wd4;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
// A forwarding instance and a storage-only instance share every input.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ra1, ra2, wa3, wa4, claim_addr;
  logic [31:0] pc_in, wd3, wd4;
  logic        we3, we4, claim_en;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        busy1, busy2, nb_busy1, nb_busy2;
  logic [4:0]  pend_cnt, nb_pend_cnt;
  logic        waw_err, nb_waw_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DW(32), .AW(4), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .pc_in(pc_in), .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy1(busy1), .busy2(busy2),
    .pend_cnt(pend_cnt), .waw_err(waw_err)
  );

  regfile_sb #(.DW(32), .AW(4), .BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nb_rd1), .rd2(nb_rd2),
    .pc_in(pc_in), .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy1(nb_busy1), .busy2(nb_busy2),
    .pend_cnt(nb_pend_cnt), .waw_err(nb_waw_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we3 = 1'b0; we4 = 1'b0; claim_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    reset = 1'b0;
    ra1 = 4'd3; ra2 = 4'd15; pc_in = 32'h100;
    wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0; claim_addr = '0;
    idle();

    // writes held during reset must neither forward nor land
    @(negedge clk);
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'h33; claim_en = 1'b1; claim_addr = 4'd3;
    #1 check("rst_rd1_no_fwd", rd1, 32'h0);
    check("rst_rd2_pc", rd2, 32'h100);
    step();
    reset = 1'b1;
    #1 check("post_rst_rd1", rd1, 32'h0);
    check("post_rst_rd2_pc", rd2, 32'h100);
    check("post_rst_busy1", {31'b0, busy1}, 32'h0);
    check("post_rst_busy2", {31'b0, busy2}, 32'h0);
    check("post_rst_pend_cnt", {27'b0, pend_cnt}, 32'h0);
    check("post_rst_waw", {31'b0, waw_err}, 32'h0);

    // collision: port 4 wins, forwarded same cycle
    we3 = 1'b1; wa3 = 4'd2; wd3 = 32'hAA; we4 = 1'b1; wa4 = 4'd2; wd4 = 32'hBB; ra1 = 4'd2;
    #1 check("collide_fwd", rd1, 32'hBB);
    check("collide_nb_old", nb_rd1, 32'h0);
    step();
    #1 check("collide_store", rd1, 32'hBB);
    check("collide_nb_store", nb_rd1, 32'hBB);

    // two distinct addresses in one cycle
    we3 = 1'b1; wa3 = 4'd1; wd3 = 32'h11; we4 = 1'b1; wa4 = 4'd6; wd4 = 32'h66;
    step();
    ra1 = 4'd1; ra2 = 4'd6;
    #1 check("dual_rd1", rd1, 32'h11);
    check("dual_rd2", rd2, 32'h66);

    // PC slot: writes and claims ignored
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hDEAD; claim_en = 1'b1; claim_addr = 4'd15;
    ra1 = 4'd15; pc_in = 32'h104;
    #1 check("pc_rd_during_wr", rd1, 32'h104);
    step();
    #1 check("pc_claim_cnt", {27'b0, pend_cnt}, 32'h0);
    check("pc_busy", {31'b0, busy1}, 32'h0);

    // claim 5, then retire through port 4
    claim_en = 1'b1; claim_addr = 4'd5;
    step();
    ra1 = 4'd5;
    #1 check("claim5_busy", {31'b0, busy1}, 32'h1);
    check("claim5_cnt", {27'b0, pend_cnt}, 32'h1);
    we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h55;
    #1 check("ret5_busy_fwd", {31'b0, busy1}, 32'h0);
    check("ret5_rd_fwd", rd1, 32'h55);
    check("ret5_nb_busy", {31'b0, nb_busy1}, 32'h1);
    step();
    #1 check("ret5_cnt", {27'b0, pend_cnt}, 32'h0);

    // write-after-write on a claimed register
    claim_en = 1'b1; claim_addr = 4'd7;
    step();
    we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h77; ra1 = 4'd7;
    step();
    #1 check("waw_pulse", {31'b0, waw_err}, 32'h1);
    check("waw_store", rd1, 32'h77);
    check("waw_busy", {31'b0, busy1}, 32'h1);
    check("waw_cnt", {27'b0, pend_cnt}, 32'h1);
    step();
    #1 check("waw_one_cycle", {31'b0, waw_err}, 32'h0);

    // port 4 overrides port 3 on the claimed register: no error, claim retired
    we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h70; we4 = 1'b1; wa4 = 4'd7; wd4 = 32'h7F;
    step();
    #1 check("ovr_no_waw", {31'b0, waw_err}, 32'h0);
    check("ovr_rd", rd1, 32'h7F);
    check("ovr_cnt", {27'b0, pend_cnt}, 32'h0);

    // claim and retire same address same cycle: set wins
    claim_en = 1'b1; claim_addr = 4'd9; we4 = 1'b1; wa4 = 4'd9; wd4 = 32'h99;
    step();
    ra1 = 4'd9;
    #1 check("set_wins_busy", {31'b0, busy1}, 32'h1);
    check("set_wins_cnt", {27'b0, pend_cnt}, 32'h1);
    check("set_wins_rd", rd1, 32'h99);

    // claims 1,2,3 then an asynchronous reset pulse between edges
    for (int i = 1; i <= 3; i++) begin
      claim_en = 1'b1; claim_addr = 4'(i);
      step();
    end
    #1 check("multi_claim_cnt", {27'b0, pend_cnt}, 32'h4);
    ra1 = 4'd2; ra2 = 4'd6;
    #1 reset = 1'b0;
    #1 check("async_rst_cnt", {27'b0, pend_cnt}, 32'h0);
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);
    check("async_rst_busy1", {31'b0, busy1}, 32'h0);
    reset = 1'b1;
    we4 = 1'b1; wa4 = 4'd2; wd4 = 32'h22;
    step();
    #1 check("rst_discard_cnt", {27'b0, pend_cnt}, 32'h0);
    check("rst_discard_rd", rd1, 32'h22);
    check("rst_discard_busy", {31'b0, busy1}, 32'h0);

    // storage-only read timing
    we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h40;
    step();
    we3 = 1'b1; wa3 = 4'd4; wd3 = 32'h44; ra1 = 4'd4;
    #1 check("nb_old_value", nb_rd1, 32'h40);
    check("byp_new_value", rd1, 32'h44);
    step();
    #1 check("nb_new_value", nb_rd1, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
